// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared encodings and helpers for the
// unified memory port arbiter and its latency counter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] top
  );
    return (v >= top) ? top : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side
// signals of the unified memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_kill;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          stall_f;
  logic          stall_m;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_done, if_rdata,
    output dm_done, dm_rdata,
    output stall_f, stall_m,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_done, if_rdata,
    input  dm_done, dm_rdata,
    input  stall_f, stall_m,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// lat_counter: loadable down-counter for fixed-latency
// units; term flags the last cycle before expiry.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         term
);
  logic [W-1:0] cnt;

  // load wins; otherwise count down to zero and hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = (cnt == W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data ports onto
// one fixed-latency memory, one access in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAT_V =
    CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] SMAX =
    CNT_W'(STARVE_MAX);

  logic [1:0]       state;
  logic             owner;
  logic             we_q;
  logic             killed;
  logic             rest;
  logic [CNT_W-1:0] starve_cnt;
  logic             lat_term;
  logic             busy;
  logic             fin;
  logic             if_ok;
  logic             starve_hit;
  logic             grant_dm;
  logic             grant_if;
  logic             grant;

  // data port first unless fetch has waited too long;
  // no grant in the cycle a completion is reported
  always_comb begin
    starve_hit = bus.if_req &&
                 (starve_cnt == SMAX);
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE && !rest) begin
      if (bus.dm_req && !starve_hit) begin
        grant_dm = 1'b1;
      end else if (bus.if_req) begin
        grant_if = 1'b1;
      end
    end
    grant = grant_dm | grant_if;
  end

  assign busy = (state != IDLE);
  assign fin = busy && lat_term;
  assign if_ok = !(killed || bus.if_kill);

  assign bus.stall_f = bus.if_req & ~bus.if_done;
  assign bus.stall_m = bus.dm_req & ~bus.dm_done;

  lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .en       (busy),
    .load_val (LAT_V),
    .term     (lat_term)
  );

  // transaction sequencing and owner bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= OWN_IF;
      we_q   <= 1'b0;
      killed <= 1'b0;
      rest   <= 1'b0;
    end else begin
      rest <= fin;
      unique case (state)
        IDLE: begin
          if (grant) begin
            state  <= ISSUE;
            owner  <= grant_dm ? OWN_DM : OWN_IF;
            we_q   <= grant_dm & bus.dm_we;
            killed <= grant_if & bus.if_kill;
          end
        end
        ISSUE, WAIT: begin
          if (owner == OWN_IF && bus.if_kill) begin
            killed <= 1'b1;
          end
          state <= lat_term ? IDLE : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // memory strobe and latched request on each grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
    end else begin
      bus.mem_en <= grant;
      bus.mem_we <= grant_dm & bus.dm_we;
      if (grant) begin
        bus.mem_addr  <= grant_dm ? bus.dm_addr
                                  : bus.if_addr;
        bus.mem_wdata <= grant_dm ? bus.dm_wdata
                                  : {DW{1'b0}};
      end
    end
  end

  // capture read data and pulse the owner's done
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.if_done  <= 1'b0;
      bus.dm_done  <= 1'b0;
      bus.if_rdata <= {DW{1'b0}};
      bus.dm_rdata <= {DW{1'b0}};
    end else begin
      bus.if_done <= fin && owner == OWN_IF && if_ok;
      bus.dm_done <= fin && owner == OWN_DM;
      if (fin && owner == OWN_IF && if_ok) begin
        bus.if_rdata <= bus.mem_rdata;
      end
      if (fin && owner == OWN_DM && !we_q) begin
        bus.dm_rdata <= bus.mem_rdata;
      end
    end
  end

  // count data grants that overtook a waiting fetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_dm) begin
      starve_cnt <= bus.if_req ?
        sat_inc(starve_cnt, SMAX) : '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end
  end
endmodule
